demux_lane_sched: RTL
=====================

# demux_lane_sched

Round-robin scheduler that sequences the Rx 1-to-2 four-bit demux stage. It accepts a valid-qualified 4-bit word stream in the clk_4f domain and buffers it in a 2-entry skid buffer. It steers words strictly alternately to lane 0 and lane 1, starting at lane 0, so the downstream byte reassembly keeps its ordering. It holds off the current lane while that lane's FIFO reports almost-full and backpressures upstream when the buffer is full.

## Interface
Parameters:
- DATA_W, 4, word width
- CNT_W, 8, width of per-lane delivered-word counters

Ports:
- clk_4f  input  1  sole clock; all state changes on its rising edge
- reset_L  input  1  synchronous, active-low reset
- en  input  1  1 = issue words to lanes; 0 = pause issue (acceptance continues)
- valid_in  input  1  upstream word valid
- data_in  input  DATA_W  upstream word
- ready_out  output  1  upstream may transfer; transfer = valid_in && ready_out
- almost_full0  input  1  lane 0 FIFO cannot take a word this cycle
- almost_full1  input  1  lane 1 FIFO cannot take a word this cycle
- push0  output  1  registered write strobe, lane 0
- push1  output  1  registered write strobe, lane 1
- data_out0  output  DATA_W  registered word, lane 0; holds last value when push0=0
- data_out1  output  DATA_W  registered word, lane 1; holds last value when push1=0
- sel  output  1  lane that receives the next issued word
- cnt0  output  CNT_W  words pushed to lane 0, modulo 2^CNT_W
- cnt1  output  CNT_W  words pushed to lane 1, modulo 2^CNT_W
- stall  output  1  1 while in state STALL
- idle  output  1  1 while in state IDLE

## Operation
- Buffer: 2-entry FIFO with occupancy count in 0..2. ready_out = reset_L && (count != 2), combinational from the count register.
- Issue condition, evaluated each cycle: count > 0 && en && !almost_full[sel].
- On issue:
  - head word is registered to data_out[sel], with push[sel]=1 for the next cycle;
  - head is popped;
  - sel toggles;
  - cnt[sel] increments, wrapping from 2^CNT_W-1 to 0.
- No lane skipping. If the lane at sel is almost-full, the word waits even when the other lane is free.
- Accept and issue in the same cycle are both performed. The net count change is +1, -1 or 0.
- No bypass path. A word accepted when count==0 is not issued in the same cycle.
- At most one push per cycle. push0 and push1 are never both 1.
- FSM, registered; its next state is computed from post-edge count, en and almost_full[sel]:
  - IDLE: count==0. Moves to RUN when a word is accepted.
  - RUN: count>0 and the issue condition is true.
  - STALL: count>0 and (en==0 or almost_full[sel]==1). Returns to RUN when the condition clears, or to IDLE when count reaches 0.
- Reset (reset_L==0 at an edge):
  - count=0, buffer contents discarded, sel=0;
  - push0=push1=0, data_out0=data_out1=0, cnt0=cnt1=0;
  - state=IDLE, so idle=1 and stall=0;
  - ready_out=0 while reset_L is 0.
  - Reset mid-operation drops buffered words. The first word after reset goes to lane 0.

## Timing
- Word accepted at edge k. Earliest issue decision is in the cycle after edge k. push/data become visible after edge k+1, giving 2-edge minimum latency.
- Sustained throughput is 1 word/cycle when en=1 and neither lane is almost-full.
- almost_full is sampled in the issue cycle. A lane must assert it at least one cycle before it can no longer absorb a push.
- ready_out deasserts in the cycle count==2. An issue that cycle frees a slot, but ready_out rises only on the next cycle, so there is no combinational path from almost_full to ready_out.
- push strobes are single-cycle per word. data_out is valid exactly when its push is 1.

## Test plan
- Reset then stream 0x1,0x2,0x3,0x4 on consecutive cycles with en=1 and no almost_full.
  - Required: lane 0 receives 0x1,0x3; lane 1 receives 0x2,0x4.
  - Pushes alternate on consecutive cycles; first push is 2 edges after the first accept.
  - Ends with cnt0=2, cnt1=2, idle=1.
- Hold almost_full0=1, then send 0xA,0xB,0xC.
  - Required: no push occurs.
  - stall=1 from the cycle after the first accept; ready_out=0 once count==2.
  - 0xC is held upstream.
  - After almost_full0 drops: lane 0 gets 0xA, lane 1 gets 0xB, lane 0 gets 0xC, in order.
- Hold en=0 while sending 2 words.
  - Required: both words buffered, stall=1, ready_out=0, no pushes.
  - On en=1: pushes resume on lane 0, then lane 1.
- With count==2 and en=1, keep valid_in asserted.
  - Required: count never exceeds 2.
  - No word is lost or duplicated; the order of data_out across lanes equals the input order.
- Pull reset_L=0 for one cycle with 2 words buffered and sel=1.
  - Required: all outputs go to 0, idle=1.
  - The next word 0x5 goes to lane 0; buffered words are never pushed.
- Push 255 words to each lane with CNT_W=8, then push one more to each lane.
  - Required: cnt0 and cnt1 read 0xFF after 255 words and wrap to 0x00 after the next push to each lane.

Source files
------------

// File: rtl/demux_lane_sched_if.sv
// Handshake and lane-side bus of the Rx 1-to-2 demux scheduler.
// slave = scheduler view, master = upstream/lane-FIFO view.
interface demux_lane_sched_if #(
  parameter int DATA_W = 4
);
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_out;
  logic              almost_full0;
  logic              almost_full1;
  logic              push0;
  logic              push1;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;

  modport slave (
    input  valid_in, data_in, almost_full0, almost_full1,
    output ready_out, push0, push1, data_out0, data_out1
  );

  modport master (
    output valid_in, data_in, almost_full0, almost_full1,
    input  ready_out, push0, push1, data_out0, data_out1
  );
endinterface

// File: rtl/demux_lane_sched.sv
// Round-robin scheduler for the Rx 1-to-2 demux: 2-entry skid buffer feeding
// lane 0 / lane 1 strictly alternately, honouring per-lane almost-full.
module demux_lane_sched #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk_4f,
  input  logic                   reset_L,
  input  logic                   en,
  demux_lane_sched_if.slave      bus,
  output logic                   sel,
  output logic [CNT_W-1:0]       cnt0,
  output logic [CNT_W-1:0]       cnt1,
  output logic                   stall,
  output logic                   idle
);
  typedef enum logic [1:0] {IDLE, RUN, STALL} state_e;

  state_e            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              sel_q, sel_d;
  logic              push0_q, push0_d, push1_q, push1_d;
  logic [DATA_W-1:0] data_out0_q, data_out0_d, data_out1_q, data_out1_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic ready, accept, issue, af_sel, af_next;

  always_comb begin
    ready   = reset_L && (count_q != 2'd2);
    accept  = bus.valid_in && ready;
    af_sel  = sel_q ? bus.almost_full1 : bus.almost_full0;
    issue   = (count_q != 2'd0) && en && !af_sel;

    mem_d       = mem_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    sel_d       = sel_q;
    push0_d     = 1'b0;
    push1_d     = 1'b0;
    data_out0_d = data_out0_q;
    data_out1_d = data_out1_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;

    if (accept) begin
      mem_d[wr_q] = bus.data_in;
      wr_d        = ~wr_q;
    end

    if (issue) begin
      rd_d  = ~rd_q;
      sel_d = ~sel_q;
      if (sel_q) begin
        push1_d     = 1'b1;
        data_out1_d = mem_q[rd_q];
        cnt1_d      = cnt1_q + CNT_W'(1);
      end else begin
        push0_d     = 1'b1;
        data_out0_d = mem_q[rd_q];
        cnt0_d      = cnt0_q + CNT_W'(1);
      end
    end

    count_d = count_q + 2'(accept) - 2'(issue);

    // State reflects the post-edge buffer against the lane that will be next.
    af_next = sel_d ? bus.almost_full1 : bus.almost_full0;
    if (count_d == 2'd0)        state_d = IDLE;
    else if (en && !af_next)    state_d = RUN;
    else                        state_d = STALL;
  end

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      mem_q       <= '{default: '0};
      sel_q       <= 1'b0;
      push0_q     <= 1'b0;
      push1_q     <= 1'b0;
      data_out0_q <= '0;
      data_out1_q <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      mem_q       <= mem_d;
      sel_q       <= sel_d;
      push0_q     <= push0_d;
      push1_q     <= push1_d;
      data_out0_q <= data_out0_d;
      data_out1_q <= data_out1_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign bus.ready_out = ready;
  assign bus.push0     = push0_q;
  assign bus.push1     = push1_q;
  assign bus.data_out0 = data_out0_q;
  assign bus.data_out1 = data_out1_q;
  assign sel           = sel_q;
  assign cnt0          = cnt0_q;
  assign cnt1          = cnt1_q;
  assign stall         = (state_q == STALL);
  assign idle          = (state_q == IDLE);
endmodule
